// File: rtl/cpu_prog_feeder.sv
// Program sequencer feeding instruction/immediate words to the CPU over run/done.
// Fetches from synchronous program memory, stops on an all-zero word, watchdogs done.
module cpu_prog_feeder #(
  parameter int word    = 16,
  parameter int AW      = 5,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  output logic            mem_rd,
  output logic [AW-1:0]   mem_addr,
  input  logic [word-1:0] mem_data,
  output logic [word-1:0] Din,
  output logic            run,
  input  logic            done,
  output logic            busy,
  output logic            halted,
  output logic            error,
  output logic [AW-1:0]   pc,
  output logic [15:0]     icount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALTED,
    S_ERROR
  } state_t;

  localparam logic [2:0] OP_MVI = 3'b100;
  localparam int         WDW    = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [word-1:0]   ir_q, ir_d;
  logic [15:0]       icount_q, icount_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              mem_rd_q, mem_rd_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    icount_d = icount_q;
    wdog_d   = wdog_q;

    case (state_q)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_d  = S_FETCH;
          pc_d     = '0;
          icount_d = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d = mem_data;
        if (mem_data == '0) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_ISSUE;
          pc_d    = pc_q + 1'b1;
          wdog_d  = '0;
        end
      end
      S_ISSUE: begin
        if (icount_q != '1) icount_d = icount_q + 16'd1;
        if (!done) wdog_d = wdog_q + 1'b1;
        // MVI ignores done here: the immediate still has to be presented.
        if (ir_q[8:6] == OP_MVI) begin
          pc_d    = pc_q + 1'b1;
          state_d = S_IMM;
        end else if (done) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM: begin
        if (!done) wdog_d = wdog_q + 1'b1;
        state_d = done ? S_FETCH : S_WAIT;
      end
      S_WAIT: begin
        if (!done) wdog_d = wdog_q + 1'b1;
        if (done) state_d = S_FETCH;
        else if (wdog_q == WD_LAST) state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    mem_rd_d   = (state_d == S_FETCH) || ((state_d == S_ISSUE) && (ir_d[8:6] == OP_MVI));
    mem_addr_d = mem_rd_d ? pc_d : '0;
    run_d      = state_d inside {S_ISSUE, S_IMM, S_WAIT};
    busy_d     = !(state_d inside {S_IDLE, S_HALTED, S_ERROR});
    halted_d   = (state_d == S_HALTED);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      icount_q   <= '0;
      wdog_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      icount_q   <= icount_d;
      wdog_q     <= wdog_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      error_q    <= error_d;
    end
  end

  // The immediate arrives from memory during IMM, so it is passed straight through.
  always_comb begin
    case (state_q)
      S_ISSUE: Din = ir_q;
      S_IMM:   Din = mem_data;
      default: Din = '0;
    endcase
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign run      = run_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign error    = error_q;
  assign pc       = pc_q;
  assign icount   = icount_q;

endmodule

// File: doc/cpu_prog_feeder.md
Name: cpu_prog_feeder

Overview:
Program sequencer that drives the instruction side of the basic CPU's run/done interface. It fetches instruction words from a synchronous program memory and presents each word on Din with run asserted. For MVI it also fetches and presents the immediate word. It waits for done before issuing the next instruction, stops on a halt word, and flags a watchdog error if done never arrives.

Parameters:
word, 16, data/instruction width (matches CPU Din)
AW, 5, program memory address width
TIMEOUT, 64, max cycles to wait for done before error (≥2)

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin execution at address 0 (sampled in IDLE, HALTED, ERROR)
mem_rd  out  1  program memory read strobe
mem_addr  out  AW  program memory address
mem_data  in  word  read data, valid the cycle after mem_rd=1
Din  out  word  instruction/immediate word to CPU
run  out  1  CPU run request
done  in  1  CPU instruction-complete pulse
busy  out  1  high in any state other than IDLE/HALTED/ERROR
halted  out  1  halt word reached
error  out  1  done watchdog expired
pc  out  AW  address of the next instruction
icount  out  16  instructions issued since start, saturating at 16'hFFFF

Behaviour:
- Reset (async, resetn=0): state=IDLE; pc=0; ir=0; icount=0; wdog=0. Outputs mem_rd=0, mem_addr=0, Din=0, run=0, busy=0, halted=0, error=0.
- Instruction format: ir[8:6]=opcode, ir[5:3]=dest, ir[2:0]=src, upper bits 0. MVI opcode=3'b100. Halt word = all zeros.
- States:
  - IDLE/HALTED/ERROR: on start=1 → FETCH. Clear pc, icount, halted, error.
  - FETCH: mem_rd=1, mem_addr=pc → LATCH.
  - LATCH: ir<=mem_data.
    - If mem_data==0 → HALTED (halted=1, pc unchanged).
    - Otherwise → ISSUE; pc<=pc+1.
  - ISSUE: run=1, Din=ir; icount increments once.
    - If opcode==MVI: mem_rd=1, mem_addr=pc; pc<=pc+1 → IMM. done is ignored in this cycle.
    - Else: if done=1 → FETCH; otherwise → WAIT.
  - IMM: run=1, Din=mem_data (immediate).
    - If done=1 → FETCH; otherwise → WAIT.
  - WAIT: run=1, Din=0.
    - If done=1 → FETCH.
    - If wdog reaches TIMEOUT-1 → ERROR (error=1, run=0).
- run deasserts in the cycle after done is sampled, i.e. the FETCH cycle.
- Din=0 in every state except ISSUE and IMM.
- wdog: cleared on entering ISSUE; increments each cycle in ISSUE/IMM/WAIT while done=0. It covers the whole instruction.
- Throughput: non-MVI with immediate done takes 3 cycles per instruction (FETCH, LATCH, ISSUE). MVI with done in IMM takes 4 cycles.
- pc wraps from 2^AW-1 to 0 with no flag, including when the MVI immediate fetch wraps.
- done while in IDLE, FETCH, LATCH, HALTED or ERROR is ignored.
- start while busy is ignored.
- resetn low mid-instruction: immediate return to reset values, run drops asynchronously.

Test Plan:
- Single MVI: mem[0]=16'h0100 (mvi R0,#6), mem[1]=16'h0006, mem[2]=16'h0000; pulse start; CPU model pulses done in IMM → sequence:
  - mem_rd at addr 0
  - ISSUE with Din=16'h0100, run=1
  - next cycle Din=16'h0006
  - FETCH addr 2, then halted=1, pc=2, icount=1
- Multi-instruction: mem = 0x0100, 0x0005, 0x0048 (mv R1,R0), 0x0081 (add R0,R1), 0x0000; done delayed 3 cycles each → run held high until each done, Din=0 in WAIT, final halted=1, pc=4, icount=3.
- Watchdog: mem[0]=0x0048, done never asserted → error=1 exactly TIMEOUT cycles after ISSUE entry, run=0; start → pc=0, error=0, FETCH.
- Reset mid-WAIT: resetn=0 asynchronously while run=1 → run=0, busy=0, pc=0, icount=0 before next clock edge; done pulses afterwards ignored.
- Wrap: AW=2, mem = 0x0048, 0x0048, 0x0100, 0x0007 (wraps to addr 0 for halt check after re-executing) with done immediate → MVI immediate read at addr 3, next FETCH at addr 0, pc wraps without error.
- Immediate halt and spurious inputs: mem[0]=0x0000 → halted=1 with run never asserted, icount=0; done pulses in IDLE/HALTED and start while busy → no state change.
